div_scheduler: RTL and testbench
================================

Name: div_scheduler

Overview:
- Upstream issue stage for the signed fixed-point divider (`div`).
- Buffers tagged divide requests from the pipeline in a FIFO and issues them one at a time over the divider's start/done interface.
- Captures quotient and status flags and returns them, in order, with the request tag on a valid/ready result port.
- Lets ray/shading stages post divides without tracking divider busy state.

Parameters:
WIDTH, 12, fixed-point word width (integer + fractional); must match the divider
FBITS, `FIXED_POINT_BITS, fractional bits; must match the divider
DEPTH, 4, request FIFO entries; power of two, >=2
TAGW, 4, request tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  FIFO can accept (not full)
in_a  in  WIDTH  signed dividend
in_b  in  WIDTH  signed divisor
in_tag  in  TAGW  request tag
div_start  out  1  one-cycle start pulse to divider
div_a  out  WIDTH  dividend to divider
div_b  out  WIDTH  divisor to divider
div_busy  in  1  divider busy
div_done  in  1  divider done pulse
div_valid  in  1  divider result valid
div_dbz  in  1  divider divide-by-zero
div_ovf  in  1  divider overflow
div_val  in  WIDTH  divider quotient
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_val  out  WIDTH  quotient
res_tag  out  TAGW  tag of the request
res_dbz  out  1  request divided by zero
res_ovf  out  1  request overflowed

Behaviour:
- Reset (rst high at posedge):
  - FIFO flushed, FSM to IDLE.
  - in_ready=1 from the next cycle; div_start=0, div_a=0, div_b=0.
  - res_valid=0, res_val=0, res_tag=0, res_dbz=0, res_ovf=0.
  - rst overrides all other same-cycle activity. Mid-operation reset drops queued and in-flight requests; the divider shares rst.
- FIFO:
  - Push on in_valid&&in_ready. in_ready = !full, combinational from the count only.
  - Simultaneous push and pop when full is not allowed: in_ready=0 when full.
  - When not full, simultaneous push/pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: if FIFO not empty and div_busy=0, pop the head into the div_a/div_b/tag registers -> ISSUE.
  - ISSUE: div_start=1 for exactly this cycle -> WAIT. div_a/div_b are held stable from ISSUE until leaving WAIT.
  - WAIT: on div_done=1, register res_val, res_dbz, res_ovf and the latched tag -> HOLD. Register res_val = div_valid ? div_val : 0.
  - HOLD: res_valid=1. On res_ready=1 -> IDLE, or directly pop the next request and -> ISSUE if the FIFO is not empty and div_busy=0.
  - res_* are stable while res_valid=1 and res_ready=0.
- Latency:
  - Request accepted at cycle t into an empty FIFO with FSM in IDLE: div_start is high in cycle t+2 (t+1 pops).
  - res_valid rises the cycle after div_done is sampled.
  - dbz/ovf from the divider's IDLE check: div_done arrives one cycle after start, so res_valid appears at t+4.
- div_done outside WAIT is ignored. res_dbz and res_ovf are never both 1.
- Results are returned strictly in request order; one request is in flight at most.
- Max occupancy is DEPTH queued + 1 in flight/held. With res_ready held low, DEPTH+1 requests are accepted before in_ready drops.

Optional Feature:
Macro DIV_SATURATE_EN.
- Defined: when div_done arrives with div_ovf=1, res_val saturates.
  - in_a sign ^ in_b sign = 0 -> max positive {0,1...1}.
  - Otherwise -> {1,0...01}, i.e. -max.
  - Same rule for div_dbz=1, using in_a sign alone.
  - Flags are still reported.
- Undefined: res_val = 0 whenever res_dbz or res_ovf is set.

Test Plan:
- WIDTH=12, FBITS=4, res_ready=1; push a=0x030 (3.0), b=0x020 (2.0), tag=5 -> div_start at t+2; res_val=0x018 (1.5), res_tag=5, flags 0.
- Push b=0x000, a=0x010, tag=1 -> res_dbz=1, res_ovf=0. res_val=0x000 without the macro; 0x7FF with DIV_SATURATE_EN.
- Push a=0x800, b=0x010, tag=2 -> res_ovf=1, res_val=0x000 without the macro, res_valid at t+4.
- res_ready=0, DEPTH=4, push 6 back-to-back with tags 0..5 -> exactly 5 accepted, in_ready=0 after the fifth. Release res_ready -> tags 0..4 return in order.
- Backpressure: hold res_ready=0 for 10 cycles in HOLD -> res_val/res_tag stable, div_start stays 0, no further pops.
- Assert rst during WAIT with 3 queued -> next cycle res_valid=0, in_ready=1, no div_start. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/div_scheduler.sv
// div_scheduler: buffers tagged divide requests in a FIFO, issues them one at a
// time to the fixed-point divider, and returns results in order with their tags.
// Optional build macro DIV_SATURATE_EN: saturate res_val on overflow/divide-by-zero.

`ifndef FIXED_POINT_BITS
`define FIXED_POINT_BITS 4
`endif

module div_scheduler #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FBITS = `FIXED_POINT_BITS,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic             div_valid,
    input  logic             div_dbz,
    input  logic             div_ovf,
    input  logic [WIDTH-1:0] div_val,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_val,
    output logic [TAGW-1:0]  res_tag,
    output logic             res_dbz,
    output logic             res_ovf
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = PTRW + 1;

    // Reject configurations the divider interface cannot support.
    if (FBITS >= WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("div_scheduler: FBITS must be < WIDTH and DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [TAGW-1:0]  mem_tag [DEPTH];
    logic [PTRW-1:0]  wr_ptr, rd_ptr;
    logic [CNTW-1:0]  count;
    logic             full, empty, push, pop, capture;
    logic [TAGW-1:0]  tag_q;
    logic [WIDTH-1:0] result_val;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // Request storage; only the pointers need flushing on reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic, FIFO pop and result capture strobes.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !div_busy) begin
                    pop        = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (div_done) begin
                    capture    = 1'b1;
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    if (!empty && !div_busy) begin
                        pop        = 1'b1;
                        next_state = S_ISSUE;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef DIV_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    // Saturated quotient: dbz takes the dividend sign, overflow the quotient sign.
    always_comb begin
        result_val = div_valid ? div_val : '0;
        if (div_dbz) begin
            result_val = div_a[WIDTH-1] ? SAT_NEG : SAT_POS;
        end else if (div_ovf) begin
            result_val = (div_a[WIDTH-1] ^ div_b[WIDTH-1]) ? SAT_NEG : SAT_POS;
        end
    end
`else
    // Flagged results carry a zero quotient.
    always_comb begin
        result_val = '0;
        if (div_valid && !div_dbz && !div_ovf) result_val = div_val;
    end
`endif

    // Operand latch, start pulse and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            tag_q     <= '0;
            res_valid <= 1'b0;
            res_val   <= '0;
            res_tag   <= '0;
            res_dbz   <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            div_start <= (next_state == S_ISSUE);
            res_valid <= (next_state == S_HOLD);
            if (pop) begin
                div_a <= mem_a[rd_ptr];
                div_b <= mem_b[rd_ptr];
                tag_q <= mem_tag[rd_ptr];
            end
            if (capture) begin
                res_val <= result_val;
                res_tag <= tag_q;
                res_dbz <= div_dbz;
                res_ovf <= div_ovf && !div_dbz;
            end
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: scoreboard bench for div_scheduler with a behavioural divider.
// Build with DIV_SATURATE_EN defined to check the saturating variant.

module tb_div_scheduler;

    localparam int W    = 12;
    localparam int TW   = 4;
    localparam int MAXV = 2047;
    localparam int MINV = -2048;
    localparam logic [W-1:0] SAT_POS = 12'h7FF;
    localparam logic [W-1:0] SAT_NEG = 12'h801;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  val;
        logic          dbz;
        logic          ovf;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [TW-1:0] in_tag;
    logic          div_start;
    logic [W-1:0]  div_a, div_b;
    logic          div_busy, div_done, div_valid, div_dbz, div_ovf;
    logic [W-1:0]  div_val;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_val;
    logic [TW-1:0] res_tag;
    logic          res_dbz, res_ovf;

    int   vectors    = 0;
    int   miscompares = 0;
    req_t exp_q[$];
    req_t iss_q[$];
    int   lat_min = 1;
    int   lat_max = 1;
    logic spur    = 1'b0;

    div_scheduler #(.WIDTH(W), .FBITS(4), .DEPTH(4), .TAGW(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_done(div_done), .div_valid(div_valid),
        .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_val(res_val), .res_tag(res_tag),
        .res_dbz(res_dbz), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Q7.4 quotient truncated toward zero, flags by range.
    function automatic req_t make_req(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [TW-1:0] tag);
        req_t r;
        int ai, bi, q;
        ai = int'($signed(a));
        bi = int'($signed(b));
        r.a = a; r.b = b; r.tag = tag;
        r.val = '0; r.dbz = 1'b0; r.ovf = 1'b0;
        if (bi == 0) begin
            r.dbz = 1'b1;
        end else begin
            q = (ai * 16) / bi;
            if (ai == MINV || bi == MINV || q > MAXV || q < -MAXV) r.ovf = 1'b1;
            else r.val = W'(q);
        end
`ifdef DIV_SATURATE_EN
        if (r.dbz)      r.val = a[W-1] ? SAT_NEG : SAT_POS;
        else if (r.ovf) r.val = (a[W-1] ^ b[W-1]) ? SAT_NEG : SAT_POS;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard input side: record every accepted request.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(make_req(in_a, in_b, in_tag));
            iss_q.push_back(make_req(in_a, in_b, in_tag));
        end
    end

    // Scoreboard output side: compare every result handshake in order.
    always @(negedge clk) begin
        req_t e;
        if (!rst && res_valid && res_ready) begin
            check("res_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_tag", 32'(res_tag), 32'(e.tag));
                check("res_val", 32'(res_val), 32'(e.val));
                check("res_dbz", 32'(res_dbz), 32'(e.dbz));
                check("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end
        end
    end

    // Behavioural divider: done after a random latency, busy in between.
    initial begin : divider_model
        int           left;
        int           lat;
        logic         s_start, s_rst, s_spur;
        logic [W-1:0] sa, sb, cur_a, cur_b;
        req_t         r, e;
        left = 0; cur_a = '0; cur_b = '0;
        div_busy = 1'b0; div_done = 1'b0; div_valid = 1'b0;
        div_dbz = 1'b0; div_ovf = 1'b0; div_val = '0;
        forever begin
            @(negedge clk);
            s_start = div_start; s_rst = rst; s_spur = spur;
            sa = div_a; sb = div_b;
            if (!s_rst && s_start) begin
                check("start_while_busy", 32'(left), 0);
                check("issue_pending", 32'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    check("issue_a", 32'(sa), 32'(e.a));
                    check("issue_b", 32'(sb), 32'(e.b));
                end
            end
            if (!s_rst && left > 0) begin
                check("div_a_stable", 32'(sa), 32'(cur_a));
                check("div_b_stable", 32'(sb), 32'(cur_b));
            end
            @(posedge clk);
            #1;
            div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0;
            div_val = W'($urandom);
            if (s_rst) begin
                left = 0;
                div_busy = 1'b0;
            end else if (left > 0 || s_start) begin
                if (left == 0) begin
                    cur_a = sa; cur_b = sb;
                    lat = $urandom_range(lat_max, lat_min);
                    left = lat;
                end
                left--;
                div_busy = (left != 0);
                if (left == 0) begin
                    r = make_req(cur_a, cur_b, '0);
                    div_done  = 1'b1;
                    div_dbz   = r.dbz;
                    div_ovf   = r.ovf;
                    div_valid = !r.dbz && !r.ovf;
                    if (div_valid) div_val = r.val;
                end
            end else if (s_spur) begin
                div_done  = 1'b1;
                div_valid = 1'b1;
                div_dbz   = $urandom_range(1, 0) == 1;
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 0);
        repeat (2) tick();
    endtask

    // One request into an idle scheduler with a 1-cycle divider; checks latency.
    task automatic push_and_time(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag, input logic [W-1:0] exp_val,
                                 input logic exp_dbz, input logic exp_ovf);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        check("lat_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_start_t1", 32'(div_start), 0);
        tick();
        @(negedge clk);
        check("lat_start_t2", 32'(div_start), 1);
        tick();
        @(negedge clk);
        check("lat_start_t3", 32'(div_start), 0);
        check("lat_res_t3", 32'(res_valid), 0);
        tick();
        @(negedge clk);
        check("lat_res_t4", 32'(res_valid), 1);
        check("lat_val", 32'(res_val), 32'(exp_val));
        check("lat_tag", 32'(res_tag), 32'(tag));
        check("lat_dbz", 32'(res_dbz), 32'(exp_dbz));
        check("lat_ovf", 32'(res_ovf), 32'(exp_ovf));
        drain("lat");
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; res_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_div_start", 32'(div_start), 0);
        check("rst_div_a", 32'(div_a), 0);
        check("rst_div_b", 32'(div_b), 0);
        check("rst_res_val", 32'(res_val), 0);
        check("rst_res_tag", 32'(res_tag), 0);
        check("rst_res_flags", 32'({res_dbz, res_ovf}), 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Directed latency vectors.
        push_and_time(12'h030, 12'h020, 4'd5, 12'h018, 1'b0, 1'b0);
`ifdef DIV_SATURATE_EN
        push_and_time(12'h010, 12'h000, 4'd1, 12'h7FF, 1'b1, 1'b0);
        push_and_time(12'h800, 12'h010, 4'd2, 12'h801, 1'b0, 1'b1);
`else
        push_and_time(12'h010, 12'h000, 4'd1, 12'h000, 1'b1, 1'b0);
        push_and_time(12'h800, 12'h010, 4'd2, 12'h000, 1'b0, 1'b1);
`endif

        // Fill with the consumer stalled: DEPTH queued plus one held.
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = W'(16 * (i + 1));
            in_b = 12'h010;
            in_tag = TW'(i);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("fill_accepted", 32'(acc), 5);
        check("fill_in_ready", 32'(in_ready), 0);

        // Backpressure in HOLD: result frozen, no issue.
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 1);
            check("bp_res_tag", 32'(res_tag), 32'(exp_q[0].tag));
            check("bp_res_val", 32'(res_val), 32'(exp_q[0].val));
            check("bp_div_start", 32'(div_start), 0);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        tick();
        res_ready = 1'b1;
        drain("fill");

        // Stray div_done with nothing in flight must not produce a result.
        spur = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("spur_res_valid", 32'(res_valid), 0);
        end
        spur = 1'b0;
        repeat (2) tick();

        // Reset while WAITing with three requests queued.
        lat_min = 8; lat_max = 8;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = 12'h020; in_tag = TW'(8 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        tick();
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        @(negedge clk);
        check("rstw_res_valid", 32'(res_valid), 0);
        check("rstw_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check("rstw_div_start", 32'(div_start), 0);
            tick();
            @(negedge clk);
        end
        tick();
        push_and_time(12'hFD0, 12'h020, 4'd7, 12'hFE8, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            va = W'($urandom);
            case ($urandom_range(9, 0))
                0:       vb = 12'h000;
                1:       vb = 12'h800;
                2, 3:    vb = W'($urandom);
                default: vb = W'($urandom_range(16'h0300, 16'h0010)) ^ ($urandom_range(1, 0) == 1 ? 12'hFFF : 12'h000);
            endcase
            if ($urandom_range(9, 0) == 0) va = 12'h800;
            in_valid  = $urandom_range(1, 0) == 1;
            in_a      = va;
            in_b      = vb;
            in_tag    = TW'($urandom);
            res_ready = $urandom_range(9, 0) < 7;
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
